systolic_odd_even_sort_block: RTL and testbench

SYSTOLIC_ODD_EVEN_SORT_BLOCK -- requirements
Module: systolic_odd_even_sort

---
 rtl/systolic_odd_even_sort_block_pkg.sv | 13 +
 rtl/systolic_odd_even_sort_block_cmp_swap.sv | 22 ++
 rtl/systolic_odd_even_sort_block.sv | 94 +++++++++
 tb/tb_systolic_odd_even_sort_block.sv | 213 +++++++++++++++++++++
 4 files changed

// File: rtl/systolic_odd_even_sort_block_pkg.sv
// Shared defaults and state encoding for the systolic odd-even transposition sorter.
package systolic_odd_even_sort_block_pkg;

  localparam int unsigned DEF_ARRAYWIDTH = 8;
  localparam int unsigned DEF_DATASIZE   = 16;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SORT = 2'd1,
    ST_DONE = 2'd2
  } state_e;

endpackage

// File: rtl/systolic_odd_even_sort_block_cmp_swap.sv
// Unsigned compare-exchange cell: lo gets the smaller operand, hi the larger; equal values pass straight through.
module oes_cmp_swap
  import systolic_odd_even_sort_block_pkg::*;
#(
  parameter int unsigned WIDTH = DEF_DATASIZE
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] lo,
  output logic [WIDTH-1:0] hi
);

  always_comb begin
    lo = a;
    hi = b;
    if (a > b) begin
      lo = b;
      hi = a;
    end
  end

endmodule

// File: rtl/systolic_odd_even_sort_block.sv
// Odd-even transposition sorter: loads N lanes, runs N phases, then registers the largest element.
module systolic_odd_even_sort_block
  import systolic_odd_even_sort_block_pkg::*;
#(
  parameter int unsigned ARRAYWIDTH = DEF_ARRAYWIDTH,
  parameter int unsigned DATASIZE   = DEF_DATASIZE
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           en,
  input  logic [ARRAYWIDTH*DATASIZE-1:0] in,
  output logic [DATASIZE-1:0]            max_out
);

  localparam int unsigned N  = ARRAYWIDTH;
  localparam int unsigned W  = DATASIZE;
  localparam int unsigned PW = $clog2(ARRAYWIDTH + 1);

  state_e         state_q, state_d;
  logic [PW-1:0]  phase_q, phase_d;
  logic [W-1:0]   r_q [N];
  logic [W-1:0]   r_d [N];
  logic [W-1:0]   max_out_q, max_out_d;
  logic [W-1:0]   lo_c [N-1];
  logic [W-1:0]   hi_c [N-1];

  // One cell per adjacent lane pair; the phase parity decides which cells are used.
  for (genvar p = 0; p < N - 1; p++) begin : g_pair
    oes_cmp_swap #(.WIDTH(W)) u_cmp_swap (
      .a  (r_q[p]),
      .b  (r_q[p+1]),
      .lo (lo_c[p]),
      .hi (hi_c[p])
    );
  end

  always_comb begin
    state_d   = state_q;
    phase_d   = phase_q;
    r_d       = r_q;
    max_out_d = max_out_q;
    case (state_q)
      ST_IDLE: begin
        if (en) begin
          for (int unsigned i = 0; i < N; i++) begin
            r_d[i] = in[i*W +: W];
          end
          phase_d = '0;
          state_d = ST_SORT;
        end
      end
      ST_SORT: begin
        // Even phase uses pairs starting on even lanes, odd phase on odd lanes.
        for (int unsigned p = 0; p < N - 1; p++) begin
          if (1'(p) == phase_q[0]) begin
            r_d[p]   = lo_c[p];
            r_d[p+1] = hi_c[p];
          end
        end
        phase_d = phase_q + PW'(1);
        if (phase_q == PW'(N - 1)) begin
          phase_d = '0;
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        max_out_d = r_q[N-1];
        state_d   = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= ST_IDLE;
      phase_q   <= '0;
      max_out_q <= '0;
      for (int unsigned i = 0; i < N; i++) begin
        r_q[i] <= '0;
      end
    end else begin
      state_q   <= state_d;
      phase_q   <= phase_d;
      max_out_q <= max_out_d;
      r_q       <= r_d;
    end
  end

  assign max_out = max_out_q;

endmodule

// File: tb/tb_systolic_odd_even_sort_block.sv
// Randomized and directed bench for the odd-even sorter, checked against a plain sort model.
module tb_systolic_odd_even_sort_block;
  import systolic_odd_even_sort_block_pkg::*;

  localparam int N = 8;
  localparam int W = 16;

  logic           clk = 1'b0;
  logic           rst;
  logic           en;
  logic [N*W-1:0] in_v;
  logic [W-1:0]   max_out;

  int errors = 0;
  int checks = 0;

  logic [W-1:0] cur   [N];
  logic [W-1:0] exp_s [N];
  logic [W-1:0] prev_max;

  always #5 clk = ~clk;

  systolic_odd_even_sort_block #(.ARRAYWIDTH(N), .DATASIZE(W)) dut (
    .clk     (clk),
    .rst     (rst),
    .en      (en),
    .in      (in_v),
    .max_out (max_out)
  );

  // Reference: ascending order of the loaded lanes by simple insertion sort.
  function automatic void build_expected();
    logic [W-1:0] t;
    for (int i = 0; i < N; i++) exp_s[i] = cur[i];
    for (int i = 1; i < N; i++) begin
      for (int j = i; j > 0; j--) begin
        if (exp_s[j-1] > exp_s[j]) begin
          t = exp_s[j-1]; exp_s[j-1] = exp_s[j]; exp_s[j] = t;
        end
      end
    end
  endfunction

  function automatic void pack_cur();
    for (int i = 0; i < N; i++) in_v[i*W +: W] = cur[i];
  endfunction

  function automatic int r_mismatches();
    int n = 0;
    for (int i = 0; i < N; i++) if (dut.r_q[i] !== exp_s[i]) n++;
    return n;
  endfunction

  function automatic int r_nonzero();
    int n = 0;
    for (int i = 0; i < N; i++) if (dut.r_q[i] !== '0) n++;
    return n;
  endfunction

  // Pulse en for one edge; returns at the falling edge after the last phase.
  task automatic start_pulse();
    @(negedge clk);
    pack_cur();
    build_expected();
    en = 1'b1;
    @(negedge clk);
    en = 1'b0;
    repeat (8) @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b0; en = 1'b0; in_v = '0;
    repeat (3) @(negedge clk);
    checks++; if (max_out !== 16'h0) begin errors++; $display("FAIL reset_max got %h want 0000", max_out); end
    checks++; if (dut.state_q !== ST_IDLE) begin errors++; $display("FAIL reset_state got %0d want IDLE", dut.state_q); end
    checks++; if (r_nonzero() != 0) begin errors++; $display("FAIL reset_r got %0d nonzero lanes want 0", r_nonzero()); end
    rst = 1'b1;
    for (int i = 0; i < N; i++) in_v[i*W +: W] = 16'(i + 1);
    repeat (4) @(negedge clk);
    checks++; if (dut.state_q !== ST_IDLE || max_out !== 16'h0) begin
      errors++; $display("FAIL idle_no_en got state=%0d max=%h want IDLE 0000", dut.state_q, max_out);
    end
    prev_max = '0;
  endtask

  task automatic test_directed();
    for (int t = 0; t < 4; t++) begin
      for (int i = 0; i < N; i++) begin
        case (t)
          0: cur[i] = (i == 0) ? 16'd3 : (i == 1) ? 16'd7 : (i == 2) ? 16'd1 : (i == 3) ? 16'd9 :
                      (i == 4) ? 16'd0 : (i == 5) ? 16'd5 : (i == 6) ? 16'd2 : 16'd8;
          1: cur[i] = 16'(8 - i);
          2: cur[i] = (i % 2 == 0) ? 16'hFFFF : 16'h0000;
          default: cur[i] = 16'h1234;
        endcase
      end
      start_pulse();
      checks++; if (dut.state_q !== ST_DONE) begin errors++; $display("FAIL dir%0d_state got %0d want DONE", t, dut.state_q); end
      checks++; if (r_mismatches() != 0) begin errors++; $display("FAIL dir%0d_sorted got %0d wrong lanes want 0", t, r_mismatches()); end
      checks++; if (max_out !== prev_max) begin errors++; $display("FAIL dir%0d_hold got %h want %h", t, max_out, prev_max); end
      @(negedge clk);
      checks++; if (max_out !== exp_s[N-1]) begin errors++; $display("FAIL dir%0d_max got %h want %h", t, max_out, exp_s[N-1]); end
      checks++; if (dut.state_q !== ST_IDLE) begin errors++; $display("FAIL dir%0d_idle got %0d want IDLE", t, dut.state_q); end
      prev_max = exp_s[N-1];
    end
  endtask

  task automatic test_random();
    for (int t = 0; t < 12; t++) begin
      for (int i = 0; i < N; i++)
        cur[i] = (t % 3 == 0) ? 16'($urandom_range(0, 3)) : 16'($urandom);
      start_pulse();
      checks++; if (r_mismatches() != 0) begin errors++; $display("FAIL rnd%0d_sorted got %0d wrong lanes want 0", t, r_mismatches()); end
      @(negedge clk);
      checks++; if (max_out !== exp_s[N-1]) begin errors++; $display("FAIL rnd%0d_max got %h want %h", t, max_out, exp_s[N-1]); end
      prev_max = exp_s[N-1];
    end
  endtask

  task automatic test_ignore_inputs();
    for (int i = 0; i < N; i++) cur[i] = 16'($urandom);
    @(negedge clk);
    pack_cur();
    build_expected();
    en = 1'b1;
    for (int j = 1; j <= 8; j++) begin
      @(negedge clk);
      in_v = {$urandom, $urandom, $urandom, $urandom};
      en = (j == 8) ? 1'b1 : 1'($urandom);
    end
    @(negedge clk);
    en = 1'b0;
    checks++; if (r_mismatches() != 0) begin errors++; $display("FAIL ignore_sorted got %0d wrong lanes want 0", r_mismatches()); end
    @(negedge clk);
    checks++; if (max_out !== exp_s[N-1]) begin errors++; $display("FAIL ignore_max got %h want %h", max_out, exp_s[N-1]); end
    checks++; if (dut.state_q !== ST_IDLE) begin errors++; $display("FAIL ignore_idle got %0d want IDLE", dut.state_q); end
    prev_max = exp_s[N-1];
  endtask

  task automatic test_reset_mid_sort();
    for (int i = 0; i < N; i++) cur[i] = 16'($urandom) | 16'h0100;
    @(negedge clk);
    pack_cur();
    en = 1'b1;
    @(negedge clk);
    en = 1'b0;
    repeat (3) @(negedge clk);
    checks++; if (dut.phase_q !== 4'd3 || dut.state_q !== ST_SORT) begin
      errors++; $display("FAIL midsort_phase got phase=%0d state=%0d want 3 SORT", dut.phase_q, dut.state_q);
    end
    #2 rst = 1'b0;
    #1;
    checks++; if (max_out !== 16'h0) begin errors++; $display("FAIL async_max got %h want 0000", max_out); end
    checks++; if (dut.state_q !== ST_IDLE || dut.phase_q !== 4'd0) begin
      errors++; $display("FAIL async_state got state=%0d phase=%0d want IDLE 0", dut.state_q, dut.phase_q);
    end
    checks++; if (r_nonzero() != 0) begin errors++; $display("FAIL async_r got %0d nonzero lanes want 0", r_nonzero()); end
    @(negedge clk);
    rst = 1'b1;
    for (int j = 0; j < 12; j++) begin
      @(negedge clk);
      checks++; if (max_out !== 16'h0 || dut.state_q !== ST_IDLE) begin
        errors++; $display("FAIL post_reset%0d got state=%0d max=%h want IDLE 0000", j, dut.state_q, max_out);
      end
    end
    prev_max = '0;
    for (int i = 0; i < N; i++) cur[i] = (i == 0) ? 16'd5 : 16'($urandom_range(0, 4));
    start_pulse();
    checks++; if (max_out !== 16'h0) begin errors++; $display("FAIL restart_hold got %h want 0000", max_out); end
    @(negedge clk);
    checks++; if (max_out !== exp_s[N-1]) begin errors++; $display("FAIL restart_max got %h want %h", max_out, exp_s[N-1]); end
    prev_max = exp_s[N-1];
  endtask

  task automatic test_back_to_back();
    state_e exp_state;
    logic [W-1:0] exp_max;
    int m;
    cur[0] = 16'd3; cur[1] = 16'd7; cur[2] = 16'd1; cur[3] = 16'd9;
    cur[4] = 16'd0; cur[5] = 16'd5; cur[6] = 16'd2; cur[7] = 16'd8;
    @(negedge clk);
    pack_cur();
    build_expected();
    en = 1'b1;
    for (int j = 1; j <= 30; j++) begin
      @(negedge clk);
      m = (j - 1) % 10;
      exp_state = (m == 9) ? ST_IDLE : (m == 8) ? ST_DONE : ST_SORT;
      exp_max = (j < 10) ? prev_max : exp_s[N-1];
      checks++; if (max_out !== exp_max || dut.state_q !== exp_state) begin
        errors++; $display("FAIL b2b_cycle%0d got max=%h state=%0d want %h %0d", j, max_out, dut.state_q, exp_max, exp_state);
      end
    end
    en = 1'b0;
    repeat (3) @(negedge clk);
    checks++; if (max_out !== 16'd9 || dut.state_q !== ST_IDLE) begin
      errors++; $display("FAIL b2b_stop got max=%h state=%0d want 0009 IDLE", max_out, dut.state_q);
    end
    prev_max = 16'd9;
  endtask

  initial begin
    test_reset();
    test_directed();
    test_random();
    test_ignore_inputs();
    test_reset_mid_sort();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
